cl_pipe: RTL and testbench

//   Parametrised, pipelined successor of the 1-bit combinational logic unit.
//   - Applies one of 8 bitwise ops to WIDTH-bit operands a, b.
//   - Two register stages with valid/ready handshake on input and output.
//   - Counts completed results.
//   - Sits between an operand producer and a result consumer in the datapath.

---
 rtl/cl_pkg.sv | 16 +
 rtl/cl_core.sv | 29 ++
 rtl/cl_pipe.sv | 124 ++++++++++++
 tb/tb_cl_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_pkg.sv
// Shared op-code definitions for the pipelined combinational logic unit.
// Codes 000-011 keep the legacy 2-bit encodings so old producers still decode correctly.
package cl_pkg;

    localparam int CL_OP_W = 3;

    localparam logic [CL_OP_W-1:0] CL_AND  = 3'b000;
    localparam logic [CL_OP_W-1:0] CL_OR   = 3'b001;
    localparam logic [CL_OP_W-1:0] CL_XOR  = 3'b010;
    localparam logic [CL_OP_W-1:0] CL_NOT  = 3'b011;
    localparam logic [CL_OP_W-1:0] CL_NAND = 3'b100;
    localparam logic [CL_OP_W-1:0] CL_NOR  = 3'b101;
    localparam logic [CL_OP_W-1:0] CL_XNOR = 3'b110;
    localparam logic [CL_OP_W-1:0] CL_PASS = 3'b111;

endpackage

// File: rtl/cl_core.sv
// Purely combinational WIDTH-bit bitwise operation decode (a, b, s -> y).
// Sits between stage 1 and stage 2 of cl_pipe.
module cl_core
    import cl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [CL_OP_W-1:0] s,
    output logic [WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        case (s)
            CL_AND:  y = a & b;
            CL_OR:   y = a | b;
            CL_XOR:  y = a ^ b;
            CL_NOT:  y = ~a;
            CL_NAND: y = ~(a & b);
            CL_NOR:  y = ~(a | b);
            CL_XNOR: y = ~(a ^ b);
            CL_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cl_pipe.sv
// Two-stage valid/ready pipeline around cl_core with a consumed-result counter.
// Optional feature: define CL_PARITY_EN to add a registered out_parity output (^out).
module cl_pipe
    import cl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [CL_OP_W-1:0] S,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
`ifdef CL_PARITY_EN
    output logic               out_parity,
`endif
    output logic [COUNT_W-1:0] op_count
);

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [CL_OP_W-1:0] s1_op_q, s1_op_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [COUNT_W-1:0] count_q, count_d;
`ifdef CL_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               s2_adv;
    logic [WIDTH-1:0]   core_y;

    cl_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a (s1_a_q),
        .b (s1_b_q),
        .s (s1_op_q),
        .y (core_y)
    );

    // Stage 2 frees up whenever it is empty or its result is being taken this cycle.
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        in_ready = !reset && (!s1_valid_q || s2_adv);

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = a;
                s1_b_d  = b;
                s1_op_d = S;
            end
        end
    end

    // out only changes on a real load so a stalled or drained result stays stable.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
`ifdef CL_PARITY_EN
        parity_d    = parity_q;
`endif
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d    = core_y;
`ifdef CL_PARITY_EN
                parity_d = ^core_y;
`endif
            end
        end

        count_d = count_q;
        if (out_valid_q && out_ready) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            count_q     <= '0;
`ifdef CL_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            count_q     <= count_d;
`ifdef CL_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign op_count  = count_q;
`ifdef CL_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_cl_pipe.sv
// Scoreboard bench for cl_pipe (WIDTH=8, COUNT_W=4); define CL_PARITY_EN to cover out_parity.
// The driver pushes hand-computed results on accept; a monitor pops them on every consume.
module tb_cl_pipe;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         S;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out;
    logic [COUNT_W-1:0] op_count;
`ifdef CL_PARITY_EN
    logic               out_parity;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             par;
        bit               chk_lat;
        int unsigned      cyc;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int          run_len  = 0;
    int          run_max  = 0;

    logic [7:0] t1_exp [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h0F, 8'h3F, 8'h03, 8'hC3, 8'hF0};
    logic [7:0] t2_exp [8] = '{8'h0A, 8'hAF, 8'hA5, 8'h55, 8'hF5, 8'h50, 8'h5A, 8'hAA};

    cl_pipe #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .S          (S),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
`ifdef CL_PARITY_EN
        .out_parity (out_parity),
`endif
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] is,
                                 input logic [7:0] exp, input bit lat, output bit first_try);
        sb_entry_t e;
        bit accepted = 0;
        first_try = 0;
        a = ia;
        b = ib;
        S = is;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted  = 1;
                first_try = (k == 0);
                e.data    = exp;
                e.par     = ^exp;
                e.chk_lat = lat;
                e.cyc     = cyc;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: got no in_ready, expected accept of op %0d", is);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every consume pops the oldest expected result.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                run_len++;
                if (run_len > run_max) run_max = run_len;
            end else begin
                run_len = 0;
            end
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_result: got %0h, expected no result", out);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", 32'(out), 32'(e.data));
`ifdef CL_PARITY_EN
                    checkOutput("parity", 32'(out_parity), 32'(e.par));
`endif
                    if (e.chk_lat) checkOutput("latency", cyc - e.cyc, 32'd2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ft;
        bit all_first;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        S = '0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out", 32'(out), 32'd0);
        checkOutput("reset_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] test 1: each op on F0/CC");
        for (int i = 0; i < 8; i++) applyStimulus(8'hF0, 8'hCC, 3'(i), t1_exp[i], 1, ft);
        drain();
        checkOutput("t1_op_count", 32'(op_count), 32'd8);

        $display("[TB] test 2: back-to-back stream");
        doReset();
        run_max   = 0;
        all_first = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'hAA, 8'h0F, 3'(i), t2_exp[i], 1, ft);
            if (!ft) all_first = 0;
        end
        drain();
        checkOutput("t2_in_ready_held", 32'(all_first), 32'd1);
        checkOutput("t2_valid_run", 32'(run_max), 32'd8);
        checkOutput("t2_op_count", 32'(op_count), 32'd8);

        $display("[TB] test 3: backpressure stall");
        out_ready = 1'b0;
        applyStimulus(8'h3C, 8'h0F, 3'b000, 8'h0C, 0, ft);
        applyStimulus(8'h3C, 8'h0F, 3'b001, 8'h3F, 0, ft);
        a = 8'h55;
        b = 8'h0F;
        S = 3'b010;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t3_stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("t3_stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("t3_stall_out", 32'(out), 32'h0C);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(8'h55, 8'h0F, 3'b010, 8'h5A, 0, ft);
        drain();
        checkOutput("t3_op_count", 32'(op_count), 32'd11);

        $display("[TB] test 4: counter wrap");
        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(8'(i), 8'h00, 3'b111, 8'(i), 1, ft);
        drain();
        checkOutput("t4_op_count_wrap", 32'(op_count), 32'd1);

        $display("[TB] test 5: reset with ops in flight");
        out_ready = 1'b0;
        applyStimulus(8'hFF, 8'h0F, 3'b000, 8'h0F, 0, ft);
        applyStimulus(8'hFF, 8'h0F, 3'b010, 8'hF0, 0, ft);
        @(negedge clk);
        checkOutput("t5_pre_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("t5_reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_op_count", 32'(op_count), 32'd0);
        checkOutput("t5_out", 32'(out), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("t5_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

`ifdef CL_PARITY_EN
        $display("[TB] test 6: parity");
        applyStimulus(8'h07, 8'h00, 3'b111, 8'h07, 1, ft);
        drain();
        checkOutput("t6_parity_hold_1", 32'(out_parity), 32'd1);
        applyStimulus(8'h03, 8'h00, 3'b111, 8'h03, 1, ft);
        drain();
        checkOutput("t6_parity_hold_0", 32'(out_parity), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
